mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter.sv | 72 +++++++
 tb/tb_mod_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with parallel load, optional saturation and a combinational
// terminal-count carry so stages can be chained into multi-digit counters.
module mod_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter longint unsigned  MODULUS  = 256,
  parameter int unsigned      SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             terminal;
  logic             load_oor;

  assign terminal = up_dn ? (count_q == MaxVal) : (count_q == '0);
  // Compared at 64 bits so MODULUS = 2^WIDTH never flags an in-range value.
  assign load_oor = 64'(load_val) >= MODULUS;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_oor) begin
        count_d    = MaxVal;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (terminal) begin
        if (SATURATE == 0) begin
          count_d = up_dn ? '0 : MaxVal;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;
  assign carry_out = en & ~load & ~rst & terminal;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: wrap, saturating, two-stage chained and power-of-two
// instances share one stimulus bus; each expectation names the instance it applies to.
module tb_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] a_cnt, s_cnt, lo_cnt, hi_cnt;
  logic [2:0] c_cnt;
  logic       a_co, a_w, a_e, s_co, s_w, s_e, lo_co, lo_w, lo_e, hi_co, hi_w, hi_e;
  logic       c_co, c_w, c_e;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(a_cnt), .carry_out(a_co), .wrap(a_w), .load_err(a_e)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(s_cnt), .carry_out(s_co), .wrap(s_w), .load_err(s_e)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(lo_cnt), .carry_out(lo_co), .wrap(lo_w), .load_err(lo_e)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .clk(clk), .rst(rst), .en(lo_co), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(hi_cnt), .carry_out(hi_co), .wrap(hi_w), .load_err(hi_e)
  );

  mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[2:0]),
    .count(c_cnt), .carry_out(c_co), .wrap(c_w), .load_err(c_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0 = wrap, 1 = saturate, 2 = chained pair {hi,lo}, 3 = 3-bit modulo 8
  logic [7:0] o_cnt[4];
  logic       o_co[4], o_w[4], o_e[4];
  assign o_cnt[0] = {4'd0, a_cnt};
  assign o_cnt[1] = {4'd0, s_cnt};
  assign o_cnt[2] = {hi_cnt, lo_cnt};
  assign o_cnt[3] = {5'd0, c_cnt};
  assign o_co[0] = a_co;
  assign o_co[1] = s_co;
  assign o_co[2] = hi_co;
  assign o_co[3] = c_co;
  assign o_w[0] = a_w;
  assign o_w[1] = s_w;
  assign o_w[2] = hi_w;
  assign o_w[3] = c_w;
  assign o_e[0] = a_e;
  assign o_e[1] = s_e;
  assign o_e[2] = hi_e | lo_e;
  assign o_e[3] = c_e;

  typedef struct {
    int         sel;
    logic       carry;
    logic [7:0] cnt;
    logic       wrap;
    logic       err;
    string      name;
  } item_t;

  item_t q[$];
  item_t pend;
  bit    have_pend;
  int    n_tests;
  int    n_fail;

  function automatic void chk(string name, string field, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, want %0h", name, field, act, exp);
    end
  endfunction

  // Carry is checked in the cycle its inputs are applied; registered outputs one cycle later.
  always @(negedge clk) begin
    item_t it;
    if (have_pend) begin
      chk(pend.name, "count", o_cnt[pend.sel], pend.cnt);
      chk(pend.name, "wrap", {7'd0, o_w[pend.sel]}, {7'd0, pend.wrap});
      chk(pend.name, "load_err", {7'd0, o_e[pend.sel]}, {7'd0, pend.err});
    end
    have_pend = 1'b0;
    if (q.size() > 0) begin
      it = q.pop_front();
      chk(it.name, "carry_out", {7'd0, o_co[it.sel]}, {7'd0, it.carry});
      pend      = it;
      have_pend = 1'b1;
    end
  end

  task automatic step(input int sel, input logic r, input logic ld, input logic [3:0] lv,
                      input logic e, input logic ud, input logic ec, input logic [7:0] ecnt,
                      input logic ew, input logic eerr, input string nm);
    @(posedge clk);
    #1;
    rst      = r;
    load     = ld;
    load_val = lv;
    en       = e;
    up_dn    = ud;
    q.push_back('{sel: sel, carry: ec, cnt: ecnt, wrap: ew, err: eerr, name: nm});
  endtask

  initial begin
    int cur;
    int nxt;
    n_tests   = 0;
    n_fail    = 0;
    have_pend = 1'b0;
    rst       = 1'b0;
    load      = 1'b0;
    load_val  = 4'd0;
    en        = 1'b0;
    up_dn     = 1'b1;

    // Wrapping counter: up through the terminal count
    step(0, 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, "a_reset");
    for (int i = 0; i < 12; i++) begin
      cur = i % 10;
      step(0, 0, 0, 0, 1, 1, cur == 9, 8'((cur + 1) % 10), cur == 9, 0, "a_up");
    end
    // Down through zero, holds and direction changes
    step(0, 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, "a_reset2");
    step(0, 0, 0, 0, 1, 0, 1, 8'd9, 1, 0, "a_dn_wrap");
    step(0, 0, 0, 0, 1, 0, 0, 8'd8, 0, 0, "a_dn");
    step(0, 0, 0, 0, 0, 0, 0, 8'd8, 0, 0, "a_hold");
    step(0, 0, 0, 0, 1, 1, 0, 8'd9, 0, 0, "a_up_to9");
    step(0, 0, 0, 0, 0, 1, 0, 8'd9, 0, 0, "a_term_no_en");
    step(0, 0, 0, 0, 1, 0, 0, 8'd8, 0, 0, "a_dir_flip");
    // Loads: in range, out of range, boundary, load overriding a terminal count
    step(0, 0, 1, 4'd7, 1, 1, 0, 8'd7, 0, 0, "a_load7");
    step(0, 0, 1, 4'd12, 1, 1, 0, 8'd9, 0, 1, "a_load12");
    step(0, 0, 0, 0, 0, 1, 0, 8'd9, 0, 0, "a_err_clear");
    step(0, 0, 1, 4'd10, 0, 1, 0, 8'd9, 0, 1, "a_load10");
    step(0, 0, 1, 4'd9, 1, 1, 0, 8'd9, 0, 0, "a_load9");
    step(0, 0, 1, 4'd3, 1, 1, 0, 8'd3, 0, 0, "a_load_at_term");
    step(0, 0, 1, 4'd15, 0, 1, 0, 8'd9, 0, 1, "a_load15");
    // Reset beats load, en and pending pulses
    step(0, 1, 1, 4'd12, 1, 1, 0, 8'd0, 0, 0, "a_rst_over_load");
    step(0, 0, 1, 4'd9, 0, 1, 0, 8'd9, 0, 0, "a_reload9");
    step(0, 1, 0, 0, 1, 1, 0, 8'd0, 0, 0, "a_rst_over_wrap");
    step(0, 0, 0, 0, 1, 1, 0, 8'd1, 0, 0, "a_after_rst");

    // Saturating counter
    step(1, 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, "s_reset");
    step(1, 0, 0, 0, 1, 0, 1, 8'd0, 0, 0, "s_dn_hold");
    step(1, 0, 0, 0, 1, 0, 1, 8'd0, 0, 0, "s_dn_hold2");
    step(1, 0, 0, 0, 1, 1, 0, 8'd1, 0, 0, "s_up");
    step(1, 0, 1, 4'd9, 0, 1, 0, 8'd9, 0, 0, "s_load9");
    step(1, 0, 0, 0, 1, 1, 1, 8'd9, 0, 0, "s_up_hold");
    step(1, 0, 1, 4'd12, 1, 1, 0, 8'd9, 0, 1, "s_load12");
    step(1, 0, 0, 0, 1, 0, 0, 8'd8, 0, 0, "s_dn");

    // Two chained decades: 100 enabled cycles return to 00 with one upper wrap
    step(2, 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, "ch_reset");
    for (int i = 0; i < 100; i++) begin
      nxt = (i + 1) % 100;
      step(2, 0, 0, 0, 1, 1, i == 99, 8'((nxt / 10) * 16 + nxt % 10), i == 99, 0, "ch_up");
    end

    // Modulus equal to 2^WIDTH
    step(3, 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, "c_reset");
    for (int i = 0; i < 17; i++) begin
      cur = i % 8;
      step(3, 0, 0, 0, 1, 1, cur == 7, 8'((cur + 1) % 8), cur == 7, 0, "c_up");
    end

    @(posedge clk);
    #1;
    en   = 1'b0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0 || have_pend) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
